// File: rtl/round_step_sequencer.sv
// round_step_sequencer
// Sequences one 16-step round of a four-round hash-style datapath.
// A start request latches the round number and then walks steps 0..15.
// For each step the block presents the message-word index, the rotate
// amount and the constant-ROM address for the datapath to use.
// All step outputs are held at zero whenever the sequencer is not running.

module round_step_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_rnd,
  input  logic [1:0] round,
  input  logic       abort,
  output logic       step_en,
  output logic [3:0] step_idx,
  output logic [3:0] msg_idx,
  output logic [5:0] k_addr,
  output logic [4:0] shift,
  output logic       busy,
  output logic       done_rnd
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Message schedule: msg_idx = (MUL * step + OFF) mod 16, one pair per round.
  localparam logic [3:0] MSG_MUL [4] = '{4'd1, 4'd5, 4'd3, 4'd7};
  localparam logic [3:0] MSG_OFF [4] = '{4'd0, 4'd1, 4'd5, 4'd0};

  // Rotate amounts indexed by {round, step[1:0]}.
  localparam logic [4:0] SHIFT_TAB [16] = '{
    5'd7, 5'd12, 5'd17, 5'd22,
    5'd5, 5'd9,  5'd14, 5'd20,
    5'd4, 5'd11, 5'd16, 5'd23,
    5'd6, 5'd10, 5'd15, 5'd21
  };

  state_t     state_reg;
  logic [1:0] round_reg;
  logic [3:0] step_reg;
  logic       step_en_reg;
  logic       busy_reg;
  logic       done_reg;

  logic       run;
  logic [3:0] msg_cand [4];

  // Round FSM: state, latched round, step counter and registered status flags.
  // Status flags are loaded with the value that matches the next state so
  // they stay aligned with state_reg without extra decode delay.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= IDLE;
      round_reg   <= '0;
      step_reg    <= '0;
      step_en_reg <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          // An abort arriving with the start request cancels it outright.
          if (start_rnd && !abort) begin
            state_reg   <= RUN;
            round_reg   <= round;
            step_reg    <= '0;
            step_en_reg <= 1'b1;
            busy_reg    <= 1'b1;
          end
        end

        RUN: begin
          if (abort) begin
            // Abort wins over completion: no DONE cycle, no done pulse.
            state_reg   <= IDLE;
            step_reg    <= '0;
            step_en_reg <= 1'b0;
            busy_reg    <= 1'b0;
          end else if (step_reg == 4'd15) begin
            // Last step executed; leave RUN instead of wrapping to step 0.
            state_reg   <= DONE;
            step_reg    <= '0;
            step_en_reg <= 1'b0;
            done_reg    <= 1'b1;
          end else begin
            step_reg <= step_reg + 4'd1;
          end
        end

        DONE: begin
          // Completion lasts exactly one cycle; abort leads to the same place.
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end

        default: begin
          state_reg   <= IDLE;
          step_reg    <= '0;
          step_en_reg <= 1'b0;
          busy_reg    <= 1'b0;
          done_reg    <= 1'b0;
        end
      endcase
    end
  end

  assign run = (state_reg == RUN);

  // One message-index candidate per round; the latched round picks one.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_msg
      assign msg_cand[gi] = MSG_MUL[gi] * step_reg + MSG_OFF[gi];
    end
  endgenerate

  // Step outputs are forced to zero outside RUN so the datapath sees a clean idle bus.
  always_comb begin
    step_idx = '0;
    msg_idx  = '0;
    k_addr   = '0;
    shift    = '0;
    if (run) begin
      step_idx = step_reg;
      msg_idx  = msg_cand[round_reg];
      k_addr   = {round_reg, step_reg};
      shift    = SHIFT_TAB[{round_reg, step_reg[1:0]}];
    end
  end

  assign step_en  = step_en_reg;
  assign busy     = busy_reg;
  assign done_rnd = done_reg;

endmodule

// File: tb/tb_round_step_sequencer.sv
// Directed bench for round_step_sequencer: reset behaviour, full rounds for
// every round number, abort, ignored start requests, and reset mid-round.

module tb_round_step_sequencer;

  logic       clk;
  logic       rst;
  logic       start_rnd;
  logic [1:0] round;
  logic       abort;
  logic       step_en;
  logic [3:0] step_idx;
  logic [3:0] msg_idx;
  logic [5:0] k_addr;
  logic [4:0] shift;
  logic       busy;
  logic       done_rnd;

  int n_checks = 0;
  int n_fails  = 0;

  round_step_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start_rnd (start_rnd),
    .round     (round),
    .abort     (abort),
    .step_en   (step_en),
    .step_idx  (step_idx),
    .msg_idx   (msg_idx),
    .k_addr    (k_addr),
    .shift     (shift),
    .busy      (busy),
    .done_rnd  (done_rnd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int exp_msg(input int r, input int s);
    case (r)
      0:       return s % 16;
      1:       return (5 * s + 1) % 16;
      2:       return (3 * s + 5) % 16;
      default: return (7 * s) % 16;
    endcase
  endfunction

  function automatic int exp_shift(input int r, input int s);
    int tab [16] = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};
    return tab[r * 4 + (s % 4)];
  endfunction

  task automatic check_idle(input string tag);
    check_val({tag, "_step_en"},  int'(step_en),  0);
    check_val({tag, "_busy"},     int'(busy),     0);
    check_val({tag, "_done"},     int'(done_rnd), 0);
    check_val({tag, "_step_idx"}, int'(step_idx), 0);
    check_val({tag, "_msg_idx"},  int'(msg_idx),  0);
    check_val({tag, "_k_addr"},   int'(k_addr),   0);
    check_val({tag, "_shift"},    int'(shift),    0);
  endtask

  // Full round with every step checked against the schedule, one step also
  // against hand-computed values, plus start requests ignored in DONE.
  task automatic run_round(input int r, input int hs, input int hm, input int hsh, input int hk);
    round     = 2'(r);
    start_rnd = 1'b1;
    tick();
    start_rnd = 1'b0;
    round     = 2'(r + 1);
    for (int s = 0; s < 16; s++) begin
      string t;
      t = $sformatf("r%0d_s%0d", r, s);
      check_val({t, "_en"},    int'(step_en),  1);
      check_val({t, "_busy"},  int'(busy),     1);
      check_val({t, "_done"},  int'(done_rnd), 0);
      check_val({t, "_idx"},   int'(step_idx), s);
      check_val({t, "_msg"},   int'(msg_idx),  exp_msg(r, s));
      check_val({t, "_shift"}, int'(shift),    exp_shift(r, s));
      check_val({t, "_k"},     int'(k_addr),   r * 16 + s);
      if (s == hs) begin
        check_val({t, "_hand_msg"},   int'(msg_idx), hm);
        check_val({t, "_hand_shift"}, int'(shift),   hsh);
        check_val({t, "_hand_k"},     int'(k_addr),  hk);
      end
      tick();
    end
    // Cycle T+17: one-cycle completion pulse, step outputs idle.
    check_val($sformatf("r%0d_done_pulse", r), int'(done_rnd), 1);
    check_val($sformatf("r%0d_done_busy", r),  int'(busy),     1);
    check_val($sformatf("r%0d_done_en", r),    int'(step_en),  0);
    check_val($sformatf("r%0d_done_idx", r),   int'(step_idx), 0);
    check_val($sformatf("r%0d_done_msg", r),   int'(msg_idx),  0);
    check_val($sformatf("r%0d_done_shift", r), int'(shift),    0);
    check_val($sformatf("r%0d_done_k", r),     int'(k_addr),   0);
    start_rnd = 1'b1;
    tick();
    start_rnd = 1'b0;
    check_idle($sformatf("r%0d_after", r));
    $display("round %0d complete: checks=%0d fails=%0d", r, n_checks, n_fails);
  endtask

  initial begin
    rst       = 1'b0;
    start_rnd = 1'b1;
    abort     = 1'b1;
    round     = 2'd3;

    // Reset overrides start/abort.
    tick();
    tick();
    check_idle("in_reset");
    rst       = 1'b1;
    start_rnd = 1'b0;
    abort     = 1'b0;
    tick();
    check_idle("post_reset");
    $display("reset checks done: fails=%0d", n_fails);

    // Full rounds, covering all 64 (round, step) pairs.
    run_round(0, 3,  3,  22, 3);
    run_round(1, 2,  11, 14, 18);
    run_round(2, 15, 2,  23, 47);
    run_round(3, 7,  1,  21, 55);

    // Abort together with start in IDLE keeps the block idle.
    start_rnd = 1'b1;
    abort     = 1'b1;
    round     = 2'd1;
    tick();
    start_rnd = 1'b0;
    abort     = 1'b0;
    check_idle("abort_with_start");
    $display("abort+start in IDLE: fails=%0d", n_fails);

    // Abort at step 5.
    round     = 2'd1;
    start_rnd = 1'b1;
    tick();
    start_rnd = 1'b0;
    for (int s = 0; s < 5; s++) tick();
    check_val("abort_pre_idx", int'(step_idx), 5);
    check_val("abort_pre_msg", int'(msg_idx), 10);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_idle("abort_next");
    tick();
    check_idle("abort_gap");
    round     = 2'd2;
    start_rnd = 1'b1;
    tick();
    start_rnd = 1'b0;
    check_val("restart_en",  int'(step_en),  1);
    check_val("restart_idx", int'(step_idx), 0);
    check_val("restart_msg", int'(msg_idx),  5);
    check_val("restart_k",   int'(k_addr),   32);
    $display("abort at step 5 and restart: fails=%0d", n_fails);
    for (int s = 0; s < 15; s++) tick();
    check_val("restart_last_idx", int'(step_idx), 15);
    // Abort on the last step: no DONE cycle.
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_idle("abort_last_step");
    $display("abort at step 15: fails=%0d", n_fails);

    // Start with round=2 mid-RUN of round 1 is ignored; then reset at step 9.
    round     = 2'd1;
    start_rnd = 1'b1;
    tick();
    start_rnd = 1'b0;
    for (int s = 0; s < 4; s++) tick();
    check_val("ign_pre_idx", int'(step_idx), 4);
    round     = 2'd2;
    start_rnd = 1'b1;
    tick();
    start_rnd = 1'b0;
    check_val("ign_idx", int'(step_idx), 5);
    check_val("ign_msg", int'(msg_idx),  10);
    check_val("ign_k",   int'(k_addr),   21);
    for (int s = 0; s < 4; s++) tick();
    check_val("ign_s9_idx",   int'(step_idx), 9);
    check_val("ign_s9_msg",   int'(msg_idx),  14);
    check_val("ign_s9_shift", int'(shift),    9);
    $display("start ignored mid-RUN: fails=%0d", n_fails);
    rst = 1'b0;
    tick();
    check_idle("rst_mid_run");
    rst = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      check_val($sformatf("rst_quiet_c%0d_en", c),   int'(step_en),  0);
      check_val($sformatf("rst_quiet_c%0d_done", c), int'(done_rnd), 0);
    end
    $display("reset at step 9: fails=%0d", n_fails);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/round_step_sequencer.md
ROUND_STEP_SEQUENCER -- requirements
Module: round_step_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous reset, active-low: sampled only on rising clk, 0 = reset.
REQ-004 start_rnd  input  1  one-cycle request to run one 16-step round.
REQ-005 round  input  2  round number 0..3, sampled when start_rnd is accepted.
REQ-006 abort  input  1  cancels the round in progress.
REQ-007 step_en  output  1  high for each cycle in which the datapath executes one step.
REQ-008 step_idx  output  4  current step 0..15.
REQ-009 msg_idx  output  4  message-word index for the current step.
REQ-010 k_addr  output  6  constant-ROM address, {latched round, step_idx}.
REQ-011 shift  output  5  rotate amount for the current step.
REQ-012 busy  output  1  high whenever the state is not IDLE.
REQ-013 done_rnd  output  1  one-cycle pulse at round completion.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-015 IDLE -> RUN when start_rnd=1; round is latched and the step counter is cleared in the same edge.
REQ-016 RUN SHALL hold for 16 cycles with step_en=1; the step counter increments by 1 each cycle.
REQ-017 RUN -> DONE on the edge where step_idx=15; the counter SHALL NOT wrap into a 17th step.
REQ-018 DONE SHALL assert done_rnd=1 for one cycle, then transition unconditionally to IDLE.
REQ-019 Latency: start_rnd at edge T -> step_en high in cycles T+1..T+16 -> done_rnd in cycle T+17 -> IDLE at T+18.
REQ-020 start_rnd SHALL be ignored in RUN and DONE; the latched round SHALL NOT change until the next accepted start.
REQ-021 abort=1 in RUN or DONE SHALL force IDLE on the next edge; done_rnd SHALL be 0 in that cycle (abort has priority over completion).
REQ-022 abort=1 together with start_rnd=1 in IDLE: the block SHALL remain in IDLE.
REQ-023 msg_idx SHALL be computed mod 16 from step i: round 0 -> i; round 1 -> 5i+1; round 2 -> 3i+5; round 3 -> 7i.
REQ-024 shift SHALL be selected by round and i mod 4: round 0 -> 7,12,17,22; round 1 -> 5,9,14,20; round 2 -> 4,11,16,23; round 3 -> 6,10,15,21.
REQ-025 step_idx, msg_idx, k_addr and shift SHALL be combinational from state, latched round and counter, and SHALL be 0 outside RUN.
REQ-026 step_en SHALL be high only in RUN; busy SHALL be high in RUN and DONE.

Reset
REQ-027 rst=0 at any rising edge SHALL return the block to IDLE, clear the step counter and latched round, and override start_rnd and abort.
REQ-028 During reset and in the first cycle after it, all outputs SHALL be 0.
REQ-029 Reset during RUN SHALL suppress done_rnd and every further step_en.

Verification
REQ-030 round=0, start_rnd pulse -> 16 step_en cycles; at step 3: msg_idx=3, shift=22, k_addr=3; done_rnd exactly 17 cycles after start.
REQ-031 round=1 -> step 2: msg_idx=11, shift=14, k_addr=18; round=2 -> step 15: msg_idx=2, shift=23, k_addr=47.
REQ-032 round=3 -> step 7: msg_idx=1, shift=21, k_addr=55; check all 64 (round, step) pairs against REQ-023/REQ-024.
REQ-033 abort at step 5 -> busy=0 next cycle, no done_rnd; a new start 1 cycle later begins again at step 0.
REQ-034 start_rnd with round=2 pulsed mid-RUN of round 1 -> ignored, msg_idx stays on the round-1 schedule; rst=0 at step 9 -> all outputs 0, no done_rnd.
